// File: rtl/profile_multi_ci_if.sv
// Custom-instruction bus between the CPU (master) and the profiling block (slave).
interface profile_multi_ci_if;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  modport master (output ciStart, ciN, ciValueA, ciValueB, input ciDone, ciResult);
  modport slave  (input ciStart, ciN, ciValueA, ciValueB, output ciDone, ciResult);
endinterface

// File: rtl/profile_multi_ci.sv
// Multi-counter event profiler on the CPU custom-instruction bus.
// Define PROFILE_SATURATE_EN to make counters saturate instead of wrapping.
module profile_multi_ci #(
  parameter logic [7:0] customId      = 8'h00,
  parameter int         NR_COUNTERS   = 8,
  parameter int         COUNTER_WIDTH = 32,
  parameter int         NR_EVENTS     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NR_EVENTS-1:0] events,
  profile_multi_ci_if.slave    ci
);

  localparam logic [3:0] OP_READ_LO = 4'd0;
  localparam logic [3:0] OP_READ_HI = 4'd1;
  localparam logic [3:0] OP_ENABLE  = 4'd2;
  localparam logic [3:0] OP_CLEAR   = 4'd3;
  localparam logic [3:0] OP_SELECT  = 4'd4;
  localparam logic [3:0] OP_STATUS  = 4'd5;
  localparam logic [3:0] OP_CLR_OVF = 4'd6;
  localparam logic [4:0] NC         = 5'(NR_COUNTERS);

  logic                     accept;
  logic [3:0]               op;
  logic [3:0]               idx;
  logic                     idx_ok;
  logic [NR_COUNTERS-1:0]   set_mask;
  logic [NR_COUNTERS-1:0]   clr_mask;
  logic                     op_clear, op_select, op_clr_ovf;
  logic [15:0]              ev_ext;
  logic [COUNTER_WIDTH-1:0] cnt_arr [16];
  logic [NR_COUNTERS-1:0]   ovf_vec;

  logic [NR_COUNTERS-1:0]   enable_q, enable_d;
  logic [31:0]              shadow_q, shadow_d;
  logic                     done_q, done_d;
  logic [31:0]              result_q, result_d;
  logic [63:0]              rd_ext;
  logic                     unused_bits;

  assign accept     = ci.ciStart && (ci.ciN == customId);
  assign op         = ci.ciValueA[3:0];
  assign idx        = ci.ciValueA[7:4];
  assign idx_ok     = {1'b0, idx} < NC;
  assign set_mask   = ci.ciValueB[NR_COUNTERS-1:0];
  assign clr_mask   = ci.ciValueB[16 +: NR_COUNTERS];
  assign op_clear   = accept && (op == OP_CLEAR);
  assign op_select  = accept && (op == OP_SELECT) && idx_ok;
  assign op_clr_ovf = accept && (op == OP_CLR_OVF);
  // Unconnected select codes land on zero-extended bits, i.e. constant 0.
  assign ev_ext     = 16'(events);
  assign unused_bits = ^{ci.ciValueA[31:8], ci.ciValueB};

  for (genvar gi = 0; gi < NR_COUNTERS; gi++) begin : g_ctr
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]               sel_q, sel_d;
    logic                     ovf_q, ovf_d;
    logic                     inc;

    assign inc         = enable_q[gi] & ev_ext[sel_q];
    assign cnt_arr[gi] = cnt_q;
    assign ovf_vec[gi] = ovf_q;

    always_comb begin
      cnt_d = cnt_q;
      sel_d = sel_q;
      ovf_d = ovf_q;
      if (op_clr_ovf && set_mask[gi]) ovf_d = 1'b0;
      // A wrap/saturation in the same cycle as CLR_OVF leaves the flag set.
      if (inc) begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
`ifdef PROFILE_SATURATE_EN
          cnt_d = cnt_q;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      if (op_clear && set_mask[gi]) cnt_d = '0;
      if (op_select && (idx == 4'(gi))) sel_d = ci.ciValueB[3:0];
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        sel_q <= 4'(gi % NR_EVENTS);
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        sel_q <= sel_d;
        ovf_q <= ovf_d;
      end
    end
  end

  for (genvar gi = NR_COUNTERS; gi < 16; gi++) begin : g_pad
    assign cnt_arr[gi] = '0;
  end

  always_comb begin
    rd_ext   = idx_ok ? 64'(cnt_arr[idx]) : 64'd0;
    enable_d = enable_q;
    shadow_d = shadow_q;
    result_d = '0;
    done_d   = accept;
    if (accept) begin
      case (op)
        OP_READ_LO: begin
          result_d = rd_ext[31:0];
          shadow_d = rd_ext[63:32];
        end
        OP_READ_HI: result_d = shadow_q;
        OP_ENABLE:  enable_d = (enable_q | set_mask) & ~clr_mask;
        OP_STATUS:  result_d = {16'(ovf_vec), 16'(enable_q)};
        default:    result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_q <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      enable_q <= enable_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ci.ciDone   = done_q;
  assign ci.ciResult = result_q;

endmodule
